mem_access: RTL

- MEM-stage block. Consumes the memory request that EX produces: effective address on wdata, store data, load/store op type.
- Performs the access byte-serially, little-endian, over the 8-bit data port of mem_ctrl.
- Stalls the pipeline while the access is in progress. Hands the load result or pass-through ALU result to MEM/WB, and to the forwarding path.

---
 rtl/mem_access.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : MEM pipeline stage. Loads and stores go out one byte at a time,
//            little-endian, over the 8-bit mem_ctrl port. The pipeline is
//            stalled while an access runs. Results go to MEM/WB and to the
//            forwarding path.
//            States:
//              IDLE   - non-memory ops pass straight through.
//              ACCESS - one byte per grant, lowest address first.
//              DONE   - one cycle that presents the load result.
// Ports    : clk, rst (async, active-high)
//            wd_i/wreg_i/wdata_i    - EX/MEM result; wdata_i is the address
//                                     for loads and stores
//            mem_w_data_i           - store data
//            mem_op_type_i          - load/store op code (others: no mem op)
//            wd_o/wreg_o/wdata_o    - result to MEM/WB
//            stall_req_o            - stall request to ctrl
//            mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o - byte request
//            mem_gnt_i/mem_rdata_i  - byte completion and read data
//            mem_fwd_we_o/mem_fwd_rd_o/mem_fwd_data_o  - forwarding path
// Options  : MEM_ALIGN_CHECK_EN - adds mem_misalign_o. Misaligned halfword
//            and word ops are rejected with no bus traffic.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [31:0]           mem_w_data_i,
  input  logic [5:0]            mem_op_type_i,
  output logic [4:0]            wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  stall_req_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [7:0]            mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic [7:0]            mem_rdata_i,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                  mem_misalign_o,
`endif
  output logic                  mem_fwd_we_o,
  output logic [4:0]            mem_fwd_rd_o,
  output logic [31:0]           mem_fwd_data_o
);

  // Op codes, matching the defines.v encoding used by EX.
  localparam logic [5:0] c_OP_LB  = 6'd1;
  localparam logic [5:0] c_OP_LH  = 6'd2;
  localparam logic [5:0] c_OP_LW  = 6'd3;
  localparam logic [5:0] c_OP_LBU = 6'd4;
  localparam logic [5:0] c_OP_LHU = 6'd5;
  localparam logic [5:0] c_OP_SB  = 6'd6;
  localparam logic [5:0] c_OP_SH  = 6'd7;
  localparam logic [5:0] c_OP_SW  = 6'd8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           sdata_q;
  logic [31:0]           asm_q;
  logic [5:0]            op_q;
  logic [4:0]            wd_q;
  logic                  wreg_q;
  logic                  is_store_q;
  logic                  misalign_q;
  logic [2:0]            nbytes_q;
  logic [1:0]            cnt_q;

  logic                  in_is_load;
  logic                  in_is_store;
  logic                  in_is_mem;
  logic                  in_misalign;
  logic [2:0]            in_nbytes;
  logic [31:0]           load_data;
  logic                  last_byte;

  // Decode the incoming op.
  always_comb begin
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
    in_nbytes   = 3'd0;
    case (mem_op_type_i)
      c_OP_LB, c_OP_LBU: begin in_is_load  = 1'b1; in_nbytes = 3'd1; end
      c_OP_LH, c_OP_LHU: begin in_is_load  = 1'b1; in_nbytes = 3'd2; end
      c_OP_LW:           begin in_is_load  = 1'b1; in_nbytes = 3'd4; end
      c_OP_SB:           begin in_is_store = 1'b1; in_nbytes = 3'd1; end
      c_OP_SH:           begin in_is_store = 1'b1; in_nbytes = 3'd2; end
      c_OP_SW:           begin in_is_store = 1'b1; in_nbytes = 3'd4; end
      default:           ;
    endcase
  end

  assign in_is_mem = in_is_load | in_is_store;

`ifdef MEM_ALIGN_CHECK_EN
  assign in_misalign = in_is_mem &&
                       (((in_nbytes == 3'd2) && wdata_i[0]) ||
                        ((in_nbytes == 3'd4) && (wdata_i[1:0] != 2'b00)));
`else
  assign in_misalign = 1'b0;
`endif

  assign last_byte = ({1'b0, cnt_q} == (nbytes_q - 3'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      sdata_q    <= '0;
      asm_q      <= '0;
      op_q       <= '0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      is_store_q <= 1'b0;
      misalign_q <= 1'b0;
      nbytes_q   <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_is_mem) begin
            addr_q     <= ADDR_WIDTH'(wdata_i);
            sdata_q    <= mem_w_data_i;
            asm_q      <= '0;
            op_q       <= mem_op_type_i;
            wd_q       <= wd_i;
            wreg_q     <= wreg_i;
            is_store_q <= in_is_store;
            misalign_q <= in_misalign;
            nbytes_q   <= in_nbytes;
            cnt_q      <= 2'd0;
            // A rejected misaligned op skips the bus entirely.
            state_q    <= in_misalign ? S_DONE : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_gnt_i) begin
            if (!is_store_q) begin
              asm_q[{cnt_q, 3'b000} +: 8] <= mem_rdata_i;
            end
            cnt_q <= cnt_q + 2'd1;
            if (last_byte) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // The pipeline advances on this edge, so the op is not seen twice.
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Extend the assembled load value according to the latched op.
  always_comb begin
    load_data = asm_q;
    case (op_q)
      c_OP_LB:  load_data = {{24{asm_q[7]}}, asm_q[7:0]};
      c_OP_LBU: load_data = {24'h000000, asm_q[7:0]};
      c_OP_LH:  load_data = {{16{asm_q[15]}}, asm_q[15:0]};
      c_OP_LHU: load_data = {16'h0000, asm_q[15:0]};
      default:  load_data = asm_q;
    endcase
  end

  // The outputs are gated by rst so they drop in the same cycle that reset
  // asserts, even when reset arrives in the middle of an access.
  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stall_req_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          wd_o        = wd_i;
          wdata_o     = wdata_i;
          wreg_o      = wreg_i & ~in_is_mem;
          stall_req_o = in_is_mem;
        end
        S_ACCESS: begin
          stall_req_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = is_store_q;
          mem_addr_o  = addr_q + ADDR_WIDTH'(cnt_q);
          mem_wdata_o = sdata_q[{cnt_q, 3'b000} +: 8];
        end
        S_DONE: begin
          if (!is_store_q && !misalign_q) begin
            wd_o    = wd_q;
            wreg_o  = wreg_q;
            wdata_o = load_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign mem_misalign_o = !rst && (state_q == S_DONE) && misalign_q;
`endif

  assign mem_fwd_we_o   = wreg_o;
  assign mem_fwd_rd_o   = wd_o;
  assign mem_fwd_data_o = wdata_o;

endmodule
`default_nettype wire
